axil_slave_to_al: RTL and testbench
===================================

// Module: axil_slave_to_al
// PURPOSE
//  AXI4-Lite slave to AL (word-addressed valid/ready) master bridge. Accepts single-beat AXI-Lite
//  reads/writes from a host (e.g. PCIe BAR master) and issues them as AL transactions to local peripherals.
//  Write and read paths are independent FSMs; one outstanding transaction per direction.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width on the AXI side; AL side carries [ADDR_WIDTH-1:2]
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  s_axi_awaddr   in   ADDR_WIDTH  write byte address
//  s_axi_awvalid  in   1  / s_axi_awready out 1   AW handshake
//  s_axi_wdata    in   32          write data
//  s_axi_wstrb    in   4           byte strobes
//  s_axi_wvalid   in   1  / s_axi_wready  out 1   W handshake
//  s_axi_bresp    out  2           write response
//  s_axi_bvalid   out  1  / s_axi_bready  in  1   B handshake
//  s_axi_araddr   in   ADDR_WIDTH  read byte address
//  s_axi_arvalid  in   1  / s_axi_arready out 1   AR handshake
//  s_axi_rdata    out  32          read data
//  s_axi_rresp    out  2           read response
//  s_axi_rvalid   out  1  / s_axi_rready  in  1   R handshake
//  m_al_waddr     out  ADDR_WIDTH-2 AL word write address
//  m_al_wdata     out  32          AL write data
//  m_al_wvalid    out  1  / m_al_wready   in  1   AL write handshake (write complete on handshake)
//  m_al_araddr    out  ADDR_WIDTH-2 AL word read address
//  m_al_arvalid   out  1  / m_al_arready  in  1   AL read-address handshake
//  m_al_rdata     in   32          AL read data
//  m_al_rvalid    in   1  / m_al_rready   out 1   AL read-data handshake
// BEHAVIOUR
//  - All outputs registered; no combinational valid->ready path. Reset: awready=wready=arready=1,
//    all *valid=0, m_al_rready=0, bresp=rresp=OKAY, all address/data outputs 0.
//  - Write FSM W_IDLE->W_ISSUE->W_RESP->W_IDLE. In W_IDLE AW and W captured independently (any order or
//    same cycle); each ready drops the cycle after its handshake. When both held: if wstrb!=4'hF or
//    awaddr[1:0]!=0 -> W_RESP with SLVERR (2'b10), no AL write issued; else W_ISSUE.
//  - W_ISSUE: m_al_wvalid=1, waddr=awaddr[AW-1:2], wdata held stable until m_al_wready; then
//    wvalid=0, bvalid=1, bresp=OKAY. W_RESP: hold bvalid/bresp until bready; then awready=wready=1.
//  - Latency: AW+W at cycle N -> m_al_wvalid at N+1; wready at N+1 -> bvalid at N+2.
//  - Read FSM R_IDLE->R_ADDR->R_DATA->R_RESP->R_IDLE. R_IDLE: arready=1, capture araddr, arready=0.
//    araddr[1:0]!=0 -> R_RESP, rdata=0, rresp=SLVERR. Else R_ADDR: m_al_arvalid=1 until m_al_arready.
//  - R_DATA: m_al_rready=1; on m_al_rvalid capture rdata, rready=0, s_axi_rvalid=1, rresp=OKAY.
//    AL responder never asserts rvalid before its arready handshake. R_RESP: hold until s_axi_rready.
//  - Latency: arvalid at N -> m_al_arvalid N+1; m_al_rvalid at M -> s_axi_rvalid M+1.
//  - No timeout: stalled AL side stalls the AXI side indefinitely.
//  - Read and write run concurrently; no ordering enforced between them.
//  - Back-pressure: bready/rready low holds response; no new AW/W/AR accepted until response done.
//  - Reset mid-operation: FSMs return to idle immediately; in-flight AL valid dropped, transaction lost.
// STRUCTURE
//  - Shared package al_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read FSM state encodings.
//  - Single module, two independent always blocks (write FSM, read FSM); no sub-module.
// TESTING
//  - AW+W same cycle addr 0x10 data 0xA5A5_0001 strb F, m_al_wready=1 -> waddr=0x4, bvalid at N+2 OKAY.
//  - W three cycles before AW (0x20) -> single AL write waddr=0x8 after AW; wready low after W handshake.
//  - wstrb=4'h3 at 0x0 -> no m_al_wvalid ever; bresp=SLVERR; araddr=0x2 -> no AL read; rresp=SLVERR, rdata=0.
//  - Read 0x40, AL arready after 3 cycles, rvalid 2 cycles later data 0xDEAD_BEEF -> araddr=0x10, rdata match.
//  - bready/rready held low 5 cycles -> bvalid/rvalid and payload stable; next AW/AR not accepted meanwhile.
//  - Concurrent read+write, then rst_n low during W_ISSUE -> all valids 0, readies back to reset values.

Source files
------------

// File: rtl/al_pkg.sv
// Shared definitions for the AXI4-Lite to AL bridge: response codes and FSM encodings.
package al_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_RESP  = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_RESP = 2'd3
  } r_state_t;

endpackage

// File: rtl/axil_slave_to_al.sv
// AXI4-Lite slave to word-addressed AL master; independent write and read FSMs,
// one outstanding transaction per direction, every output registered.
//
// state   | meaning
// W_IDLE  | collecting AW and W (any order); awready/wready drop once each is taken
// W_ISSUE | AL write presented, waiting for m_al_wready
// W_RESP  | B response held until bready
// R_IDLE  | arready high, waiting for AR
// R_ADDR  | AL read address presented, waiting for m_al_arready
// R_DATA  | m_al_rready high, waiting for AL read data
// R_RESP  | R response held until rready
module axil_slave_to_al
  import al_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ADDR_WIDTH-3:0] m_al_waddr,
  output logic [31:0]           m_al_wdata,
  output logic                  m_al_wvalid,
  input  logic                  m_al_wready,
  output logic [ADDR_WIDTH-3:0] m_al_araddr,
  output logic                  m_al_arvalid,
  input  logic                  m_al_arready,
  input  logic [31:0]           m_al_rdata,
  input  logic                  m_al_rvalid,
  output logic                  m_al_rready
);

  w_state_t w_state;
  r_state_t r_state;

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  aw_hs, w_hs, have_aw, have_w;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [31:0]           data_eff;
  logic [3:0]            strb_eff;

  // A channel is "held" once its ready has dropped; a live handshake counts too,
  // so AW and W arriving in the same cycle issue without an extra bubble.
  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign have_aw  = aw_hs | ~s_axi_awready;
  assign have_w   = w_hs | ~s_axi_wready;
  assign addr_eff = s_axi_awready ? s_axi_awaddr : awaddr_q;
  assign data_eff = s_axi_wready ? s_axi_wdata : wdata_q;
  assign strb_eff = s_axi_wready ? s_axi_wstrb : wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      m_al_wvalid   <= 1'b0;
      m_al_waddr    <= '0;
      m_al_wdata    <= '0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q      <= s_axi_awaddr;
            s_axi_awready <= 1'b0;
          end
          if (w_hs) begin
            wdata_q      <= s_axi_wdata;
            wstrb_q      <= s_axi_wstrb;
            s_axi_wready <= 1'b0;
          end
          if (have_aw && have_w) begin
            // Partial or misaligned writes are refused without touching the AL side.
            if (strb_eff != 4'hF || addr_eff[1:0] != 2'b00) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= RESP_SLVERR;
              w_state      <= W_RESP;
            end else begin
              m_al_wvalid <= 1'b1;
              m_al_waddr  <= addr_eff[ADDR_WIDTH-1:2];
              m_al_wdata  <= data_eff;
              w_state     <= W_ISSUE;
            end
          end
        end
        W_ISSUE: begin
          if (m_al_wready) begin
            m_al_wvalid  <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= RESP_OKAY;
            w_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      m_al_arvalid  <= 1'b0;
      m_al_araddr   <= '0;
      m_al_rready   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_arready <= 1'b0;
            if (s_axi_araddr[1:0] != 2'b00) begin
              s_axi_rvalid <= 1'b1;
              s_axi_rdata  <= '0;
              s_axi_rresp  <= RESP_SLVERR;
              r_state      <= R_RESP;
            end else begin
              m_al_arvalid <= 1'b1;
              m_al_araddr  <= s_axi_araddr[ADDR_WIDTH-1:2];
              r_state      <= R_ADDR;
            end
          end
        end
        R_ADDR: begin
          if (m_al_arready) begin
            m_al_arvalid <= 1'b0;
            m_al_rready  <= 1'b1;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_al_rvalid) begin
            m_al_rready  <= 1'b0;
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= m_al_rdata;
            s_axi_rresp  <= RESP_OKAY;
            r_state      <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slave_to_al.sv
// Directed bench for axil_slave_to_al; expected AL and AXI responses are queued
// at stimulus time and popped by a monitor on every handshake.
module tb_axil_slave_to_al;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s_axi_awaddr;
  logic          s_axi_awvalid, s_axi_awready;
  logic [31:0]   s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid, s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid, s_axi_bready;
  logic [AW-1:0] s_axi_araddr;
  logic          s_axi_arvalid, s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid, s_axi_rready;
  logic [AW-3:0] m_al_waddr;
  logic [31:0]   m_al_wdata;
  logic          m_al_wvalid, m_al_wready;
  logic [AW-3:0] m_al_araddr;
  logic          m_al_arvalid, m_al_arready;
  logic [31:0]   m_al_rdata;
  logic          m_al_rvalid, m_al_rready;

  axil_slave_to_al #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
    .m_al_wready(m_al_wready), .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid),
    .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
    .m_al_rready(m_al_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_alw[$];  // {waddr, wdata}
  logic [63:0] exp_b[$];    // bresp
  logic [63:0] exp_ar[$];   // araddr
  logic [63:0] exp_r[$];    // {rresp, rdata}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (s_axi_awready && s_axi_wready && s_axi_arready && !s_axi_bvalid && !s_axi_rvalid &&
          !m_al_wvalid && !m_al_arvalid)
        done = 1;
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_readies"}, {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);
    chk({tag, "_valids"}, {59'd0, s_axi_bvalid, s_axi_rvalid, m_al_wvalid, m_al_arvalid, m_al_rready}, 64'h0);
    chk({tag, "_resps"}, {60'd0, s_axi_bresp, s_axi_rresp}, 64'h0);
    chk({tag, "_payload"}, {32'(m_al_waddr), 32'(m_al_araddr)} | {32'd0, m_al_wdata | s_axi_rdata}, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    m_al_wready = 0; m_al_arready = 0; m_al_rdata = '0; m_al_rvalid = 0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (m_al_wvalid && m_al_wready) begin
            if (exp_alw.size() == 0) chk("al_write_unexpected", 64'd1, 64'd0);
            else chk("al_write", {2'b00, m_al_waddr, m_al_wdata}, exp_alw.pop_front());
          end else if (m_al_wvalid && exp_alw.size() == 0) chk("al_wvalid_unexpected", 64'd1, 64'd0);
          if (s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else chk("bresp", 64'(s_axi_bresp), exp_b.pop_front());
          end
          if (m_al_arvalid && m_al_arready) begin
            if (exp_ar.size() == 0) chk("al_read_unexpected", 64'd1, 64'd0);
            else chk("al_araddr", 64'(m_al_araddr), exp_ar.pop_front());
          end else if (m_al_arvalid && exp_ar.size() == 0) chk("al_arvalid_unexpected", 64'd1, 64'd0);
          if (s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else chk("rresp_rdata", {30'd0, s_axi_rresp, s_axi_rdata}, exp_r.pop_front());
          end
        end
      end
    join_none

    cyc(); cyc();
    check_reset_values("reset");
    rst_n = 1'b1;
    cyc();

    // Aligned full write, AW and W together; AL accepts immediately.
    s_axi_bready = 1; m_al_wready = 1;
    exp_alw.push_back({2'b00, 30'h4, 32'hA5A5_0001});
    exp_b.push_back(64'h0);
    s_axi_awaddr = 32'h10; s_axi_awvalid = 1;
    s_axi_wdata = 32'hA5A5_0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    cyc();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("t1_wvalid_n1", 64'(m_al_wvalid), 64'd1);
    chk("t1_readies_low", {62'd0, s_axi_awready, s_axi_wready}, 64'd0);
    chk("t1_bvalid_n1", 64'(s_axi_bvalid), 64'd0);
    cyc();
    chk("t1_bvalid_n2", 64'(s_axi_bvalid), 64'd1);
    chk("t1_wvalid_drop", 64'(m_al_wvalid), 64'd0);
    wait_idle();

    // W three cycles ahead of AW.
    s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    cyc();
    s_axi_wvalid = 0;
    chk("t2_wready_low", {62'd0, s_axi_awready, s_axi_wready}, 64'h2);
    cyc(); cyc();
    chk("t2_no_early_wvalid", 64'(m_al_wvalid), 64'd0);
    exp_alw.push_back({2'b00, 30'h8, 32'h1111_2222});
    exp_b.push_back(64'h0);
    s_axi_awaddr = 32'h20; s_axi_awvalid = 1;
    cyc();
    s_axi_awvalid = 0;
    chk("t2_wvalid_after_aw", 64'(m_al_wvalid), 64'd1);
    wait_idle();

    // Partial strobe write and misaligned read: SLVERR, no AL traffic.
    s_axi_rready = 1;
    exp_b.push_back(64'h2);
    s_axi_awaddr = 32'h0; s_axi_awvalid = 1;
    s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'h3; s_axi_wvalid = 1;
    cyc();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("t3_bvalid_err", {62'd0, s_axi_bvalid, m_al_wvalid}, 64'h2);
    wait_idle();
    exp_r.push_back({30'd0, 2'b10, 32'h0});
    s_axi_araddr = 32'h2; s_axi_arvalid = 1;
    cyc();
    s_axi_arvalid = 0;
    chk("t3_rvalid_err", {62'd0, s_axi_rvalid, m_al_arvalid}, 64'h2);
    wait_idle();

    // Read with slow AL responder.
    m_al_arready = 0;
    exp_ar.push_back(64'h10);
    exp_r.push_back({30'd0, 2'b00, 32'hDEAD_BEEF});
    s_axi_araddr = 32'h40; s_axi_arvalid = 1;
    cyc();
    s_axi_arvalid = 0;
    chk("t4_arvalid_n1", {62'd0, m_al_arvalid, s_axi_arready}, 64'h2);
    cyc(); cyc(); cyc();
    chk("t4_arvalid_held", 64'(m_al_arvalid), 64'd1);
    m_al_arready = 1;
    cyc();
    m_al_arready = 0;
    chk("t4_rready_up", {62'd0, m_al_arvalid, m_al_rready}, 64'h1);
    cyc();
    m_al_rvalid = 1; m_al_rdata = 32'hDEAD_BEEF;
    cyc();
    m_al_rvalid = 0; m_al_rdata = '0;
    chk("t4_rvalid_m1", {62'd0, s_axi_rvalid, m_al_rready}, 64'h2);
    wait_idle();

    // Back-pressure on both responses for five cycles.
    s_axi_bready = 0; s_axi_rready = 0; m_al_wready = 1; m_al_arready = 1;
    exp_alw.push_back({2'b00, 30'hC, 32'h0BAD_F00D});
    exp_b.push_back(64'h0);
    exp_ar.push_back(64'h11);
    exp_r.push_back({30'd0, 2'b00, 32'h1234_5678});
    s_axi_awaddr = 32'h30; s_axi_awvalid = 1;
    s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    s_axi_araddr = 32'h44; s_axi_arvalid = 1;
    cyc();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    cyc();
    m_al_rvalid = 1; m_al_rdata = 32'h1234_5678;
    cyc();
    m_al_rvalid = 0; m_al_rdata = '0;
    s_axi_awaddr = 32'h70; s_axi_awvalid = 1; s_axi_wvalid = 1;
    s_axi_araddr = 32'h74; s_axi_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_b_hold", {61'd0, s_axi_bvalid, s_axi_bresp}, 64'h4);
      chk("t5_r_hold", {29'd0, s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {29'd0, 1'b1, 2'b00, 32'h1234_5678});
      chk("t5_no_accept", {60'd0, s_axi_awready, s_axi_wready, s_axi_arready, m_al_wvalid | m_al_arvalid}, 64'h0);
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    s_axi_bready = 1; s_axi_rready = 1;
    wait_idle();

    // Concurrent read and write, reset while the write sits in W_ISSUE.
    m_al_wready = 0; m_al_arready = 0;
    exp_alw.push_back({2'b00, 30'h14, 32'h7777_0000});
    exp_ar.push_back(64'h18);
    s_axi_awaddr = 32'h50; s_axi_awvalid = 1;
    s_axi_wdata = 32'h7777_0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    s_axi_araddr = 32'h60; s_axi_arvalid = 1;
    cyc();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    chk("t6_both_issued", {62'd0, m_al_wvalid, m_al_arvalid}, 64'h3);
    cyc();
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_midreset");
    exp_alw.delete(); exp_ar.delete(); exp_b.delete(); exp_r.delete();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Recovery write after reset.
    m_al_wready = 1; m_al_arready = 1;
    exp_alw.push_back({2'b00, 30'h2, 32'hCAFE_0002});
    exp_b.push_back(64'h0);
    s_axi_awaddr = 32'h8; s_axi_awvalid = 1;
    s_axi_wdata = 32'hCAFE_0002; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    cyc();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    wait_idle();
    cyc();

    chk("drain_alw", 64'(exp_alw.size()), 64'd0);
    chk("drain_b", 64'(exp_b.size()), 64'd0);
    chk("drain_ar", 64'(exp_ar.size()), 64'd0);
    chk("drain_r", 64'(exp_r.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
